// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module  : fifo_stream_reader
// Brief   : FIFO read-side adapter presenting FIFO words as a valid/ready
//           stream through a 3-entry skid buffer.
// Revision: 1.0
// ============================================================================
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  input  logic             flush,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned c_DEPTH = 3;

  logic [WIDTH-1:0] slot_q [c_DEPTH];
  logic [1:0]       head_q, head_d;
  logic [1:0]       tail_q, tail_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic             w_room;
  logic             w_push;
  logic             w_pop;

  function automatic logic [1:0] wrap_inc(input logic [1:0] p);
    return (p == 2'(c_DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  // Room counts the word already requested, so the buffer can never overflow.
  assign w_room     = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'(c_DEPTH);
  assign fifo_rd_en = !rst && !flush && !fifo_empty && w_room;
  assign out_valid  = (occ_q != 2'd0);
  assign out_data   = slot_q[head_q];
  assign w_push     = inflight_q && !flush;
  assign w_pop      = out_valid && out_ready;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = fifo_rd_en;
    if (flush) begin
      head_d = 2'd0;
      tail_d = 2'd0;
      occ_d  = 2'd0;
    end else begin
      if (w_pop)  head_d = wrap_inc(head_q);
      if (w_push) tail_d = wrap_inc(tail_q);
      occ_d = occ_q + 2'(w_push) - 2'(w_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= 2'd0;
      tail_q     <= 2'd0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      for (int i = 0; i < int'(c_DEPTH); i++) slot_q[i] <= '0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      if (w_push) slot_q[tail_q] <= fifo_dout;
    end
  end

endmodule
`default_nettype wire
